kronos_clint: RTL and testbench

//  Core-local interruptor: memory-mapped machine timer (mtime/mtimecmp) and software-interrupt register (msip).

---
 rtl/kronos_types.sv | 38 +++
 rtl/kronos_tick_gen.sv | 29 ++
 rtl/kronos_clint.sv | 120 ++++++++++++
 tb/tb_kronos_clint.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kronos_types.sv
// Shared types and constants for the Kronos core-local interruptor.
// Contents:
//   CLINT_*        byte offsets of the memory-mapped CLINT registers
//   MTIMECMP_RST   reset value of mtimecmp (all-ones keeps the timer quiet)
//   clint_reg_e    decoded register selector
//   merge_bytes    per-byte write merge under a Wishbone select mask
package kronos_types;

    localparam logic [31:0] CLINT_MSIP      = 32'h0000_0000;
    localparam logic [31:0] CLINT_MTIMECMP  = 32'h0000_0008;
    localparam logic [31:0] CLINT_MTIMECMPH = 32'h0000_000C;
    localparam logic [31:0] CLINT_MTIME     = 32'h0000_0010;
    localparam logic [31:0] CLINT_MTIMEH    = 32'h0000_0014;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_MTIMECMP,
        REG_MTIMECMPH,
        REG_MTIME,
        REG_MTIMEH
    } clint_reg_e;

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] result;
        result = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) result[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/kronos_tick_gen.sv
// Prescaler for the machine timer: free-running mod-PRESCALE counter that
// emits a single-cycle tick when the count reaches PRESCALE-1.
// Ports:
//   clk   in   clock
//   rst   in   asynchronous active-high reset (count -> 0)
//   tick  out  one-cycle pulse every PRESCALE clocks (constant 1 when PRESCALE = 1)
module kronos_tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(PRESCALE - 1));

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       count <= '0;
        else if (tick) count <= '0;
        else           count <= count + 1'b1;
    end

endmodule

// File: rtl/kronos_clint.sv
// Core-local interruptor: 64-bit machine timer (mtime / mtimecmp) and the
// machine software-interrupt bit (msip), exposed as a Wishbone classic slave.
// Ports:
//   clk, rst               clock; asynchronous active-high reset
//   wb_adr_i [AW-1:0]      byte address (bits [1:0] ignored)
//   wb_dat_i [31:0]        write data
//   wb_sel_i [3:0]         byte lane enables for writes
//   wb_we_i, wb_stb_i,
//   wb_cyc_i               write enable, strobe, cycle valid
//   wb_dat_o [31:0]        read data, valid while wb_ack_o = 1
//   wb_ack_o               single-cycle acknowledge, one cycle after request
//   timer_interrupt        level: mtime >= mtimecmp (registered)
//   software_interrupt     level: msip[0] (registered)
module kronos_clint
    import kronos_types::*;
#(
    parameter int PRESCALE = 1,
    parameter int AW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [31:0]   wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_stb_i,
    input  logic          wb_cyc_i,
    output logic [31:0]   wb_dat_o,
    output logic          wb_ack_o,
    output logic          timer_interrupt,
    output logic          software_interrupt
);

    logic [63:0] mtime, mtime_next;
    logic [63:0] mtimecmp, mtimecmp_next;
    logic        msip, msip_next;
    logic [31:0] mtimeh_shadow;
    logic [31:0] rdata;
    logic [AW-1:0] word_adr;
    clint_reg_e  sel_reg;
    logic        req, wr, rd, tick;

    kronos_tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // A new request is refused while ack is high, so accesses complete every 2 cycles.
    assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr       = req & wb_we_i;
    assign rd       = req & ~wb_we_i;
    assign word_adr = wb_adr_i & ~AW'(3);

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_reg = REG_NONE;
        if      (word_adr == CLINT_MSIP[AW-1:0])      sel_reg = REG_MSIP;
        else if (word_adr == CLINT_MTIMECMP[AW-1:0])  sel_reg = REG_MTIMECMP;
        else if (word_adr == CLINT_MTIMECMPH[AW-1:0]) sel_reg = REG_MTIMECMPH;
        else if (word_adr == CLINT_MTIME[AW-1:0])     sel_reg = REG_MTIME;
        else if (word_adr == CLINT_MTIMEH[AW-1:0])    sel_reg = REG_MTIMEH;
    end

    // Next-state values. A bus write to either mtime half overrides the tick:
    // the other half holds, with no increment and no carry that cycle.
    always_comb begin
        msip_next     = msip;
        mtimecmp_next = mtimecmp;
        mtime_next    = tick ? mtime + 64'd1 : mtime;
        if (wr) begin
            case (sel_reg)
                REG_MSIP:      msip_next = wb_sel_i[0] ? wb_dat_i[0] : msip;
                REG_MTIMECMP:  mtimecmp_next[31:0]  = merge_bytes(mtimecmp[31:0],  wb_dat_i, wb_sel_i);
                REG_MTIMECMPH: mtimecmp_next[63:32] = merge_bytes(mtimecmp[63:32], wb_dat_i, wb_sel_i);
                REG_MTIME:     mtime_next = {mtime[63:32], merge_bytes(mtime[31:0],  wb_dat_i, wb_sel_i)};
                REG_MTIMEH:    mtime_next = {merge_bytes(mtime[63:32], wb_dat_i, wb_sel_i), mtime[31:0]};
                default:       ;
            endcase
        end
    end

    // Reads return pre-edge state; MTIME hi returns the shadow captured by the last lo read.
    always_comb begin
        rdata = '0;
        case (sel_reg)
            REG_MSIP:      rdata = {31'b0, msip};
            REG_MTIMECMP:  rdata = mtimecmp[31:0];
            REG_MTIMECMPH: rdata = mtimecmp[63:32];
            REG_MTIME:     rdata = mtime[31:0];
            REG_MTIMEH:    rdata = mtimeh_shadow;
            default:       rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime              <= '0;
            mtimecmp           <= MTIMECMP_RST;
            msip               <= 1'b0;
            mtimeh_shadow      <= '0;
            wb_ack_o           <= 1'b0;
            wb_dat_o           <= '0;
            timer_interrupt    <= 1'b0;
            software_interrupt <= 1'b0;
        end else begin
            mtime              <= mtime_next;
            mtimecmp           <= mtimecmp_next;
            msip               <= msip_next;
            wb_ack_o           <= req;
            wb_dat_o           <= rd ? rdata : 32'h0;
            // Compare the post-update values so a cmp write takes effect on its ack edge.
            timer_interrupt    <= (mtime_next >= mtimecmp_next);
            software_interrupt <= msip_next;
            if (rd && sel_reg == REG_MTIME) mtimeh_shadow <= mtime[63:32];
        end
    end

endmodule

// File: tb/tb_kronos_clint.sv
// Directed bench for kronos_clint with PRESCALE = 4.
// A tick happens on every edge whose index since reset release is a multiple
// of PRESCALE; the small mtime model below is built on that.
module tb_kronos_clint;

    localparam int PRESCALE = 4;

    localparam logic [7:0] A_MSIP  = 8'h00;
    localparam logic [7:0] A_UNMAP = 8'h04;
    localparam logic [7:0] A_CMPL  = 8'h08;
    localparam logic [7:0] A_CMPH  = 8'h0C;
    localparam logic [7:0] A_MTL   = 8'h10;
    localparam logic [7:0] A_MTH   = 8'h14;
    localparam logic [7:0] A_HOLE  = 8'h1C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_we_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, timer_interrupt, software_interrupt;

    int n_cmp = 0;
    int n_bad = 0;

    // Edge counter since reset release: after edge k it reads k.
    int cnt;

    // mtime model: value m_base after edge m_edge, plus ticks since then.
    logic [63:0] m_base;
    int          m_edge;
    logic [63:0] cmp_model;

    kronos_clint #(.PRESCALE(PRESCALE), .AW(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .wb_adr_i           (wb_adr_i),
        .wb_dat_i           (wb_dat_i),
        .wb_sel_i           (wb_sel_i),
        .wb_we_i            (wb_we_i),
        .wb_stb_i           (wb_stb_i),
        .wb_cyc_i           (wb_cyc_i),
        .wb_dat_o           (wb_dat_o),
        .wb_ack_o           (wb_ack_o),
        .timer_interrupt    (timer_interrupt),
        .software_interrupt (software_interrupt)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cnt <= 0;
        else     cnt <= cnt + 1;
    end

    function automatic logic [63:0] mtime_at(input int k);
        return m_base + 64'(k / PRESCALE - m_edge / PRESCALE);
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                               input logic [3:0] s);
        logic [31:0] r;
        r = o;
        if (s[0]) r[7:0]   = n[7:0];
        if (s[1]) r[15:8]  = n[15:8];
        if (s[2]) r[23:16] = n[23:16];
        if (s[3]) r[31:24] = n[31:24];
        return r;
    endfunction

    task automatic model_reset();
        m_base    = '0;
        m_edge    = 0;
        cmp_model = 64'hFFFF_FFFF_FFFF_FFFF;
    endtask

    // One Wishbone access. Called just after a posedge; the request edge is the
    // next posedge. Returns read data and interrupt levels sampled after that edge.
    task automatic bus(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rdata, output int ek,
                       output logic ti, output logic si);
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (wb_ack_o !== 1'b1) begin
            n_bad++; $display("FAIL ack_rise adr=%h: got %b expected 1", adr, wb_ack_o);
        end
        rdata = wb_dat_o; ek = cnt; ti = timer_interrupt; si = software_interrupt;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (wb_ack_o !== 1'b0) begin
            n_bad++; $display("FAIL ack_single adr=%h: got %b expected 0", adr, wb_ack_o);
        end
    endtask

    task automatic wr(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      output int ek, output logic ti, output logic si);
        logic [31:0] rd_unused;
        logic [63:0] prev;
        bus(1'b1, adr, dat, sel, rd_unused, ek, ti, si);
        prev = mtime_at(ek - 1);
        case (adr)
            A_MTL:  begin m_base = {prev[63:32], lane_merge(prev[31:0], dat, sel)}; m_edge = ek; end
            A_MTH:  begin m_base = {lane_merge(prev[63:32], dat, sel), prev[31:0]}; m_edge = ek; end
            A_CMPL: cmp_model[31:0]  = lane_merge(cmp_model[31:0], dat, sel);
            A_CMPH: cmp_model[63:32] = lane_merge(cmp_model[63:32], dat, sel);
            default: ;
        endcase
    endtask

    task automatic rd(input logic [7:0] adr, output logic [31:0] data);
        int ek; logic ti, si;
        bus(1'b0, adr, 32'h0, 4'h0, data, ek, ti, si);
    endtask

    // Idle until the next access's request edge index is congruent to phase.
    task automatic align(input int phase);
        for (int i = 0; i < PRESCALE && ((cnt + 1) % PRESCALE) != phase; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_cnt(input int target);
        for (int i = 0; i < 1000 && cnt < target; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({wb_ack_o, timer_interrupt, software_interrupt} !== 3'b000 || wb_dat_o !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ack=%b ti=%b si=%b dat=%h expected all 0",
                     wb_ack_o, timer_interrupt, software_interrupt, wb_dat_o);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_free_run();
        logic [31:0] d;
        logic saw_ti;
        saw_ti = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (timer_interrupt !== 1'b0) saw_ti = 1'b1;
        end
        n_cmp++;
        if (saw_ti !== 1'b0) begin
            n_bad++; $display("FAIL free_run_ti: got 1 expected 0");
        end
        rd(A_MTL, d);
        n_cmp++;
        if (d !== 32'd10) begin
            n_bad++; $display("FAIL free_run_mtime: got %0d expected 10", d);
        end
        rd(A_CMPH, d);
        n_cmp++;
        if (d !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL cmp_reset_hi: got %h expected ffffffff", d);
        end
    endtask

    task automatic test_timer_cmp();
        int ek, rise;
        logic ti, si, exp_ti;
        wr(A_MTL, 32'h0, 4'hF, ek, ti, si);
        wr(A_CMPH, 32'h0, 4'hF, ek, ti, si);
        wr(A_CMPL, 32'd20, 4'hF, ek, ti, si);
        rise = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            exp_ti = (mtime_at(cnt) >= cmp_model);
            n_cmp++;
            if (timer_interrupt !== exp_ti) begin
                n_bad++; $display("FAIL ti_track edge %0d: got %b expected %b", cnt, timer_interrupt, exp_ti);
            end
            if (timer_interrupt === 1'b1 && rise < 0) rise = cnt;
        end
        n_cmp++;
        if (rise < 0 || mtime_at(rise) !== 64'd20) begin
            n_bad++; $display("FAIL ti_rise_point: got edge %0d expected rise when mtime becomes 20", rise);
        end
        wr(A_CMPL, 32'd1000, 4'hF, ek, ti, si);
        n_cmp++;
        if (ti !== 1'b0) begin
            n_bad++; $display("FAIL ti_fall_on_ack: got %b expected 0", ti);
        end
    endtask

    task automatic test_msip();
        int ek; logic ti, si; logic [31:0] d;
        wr(A_MSIP, 32'hFFFF_FFFF, 4'hF, ek, ti, si);
        n_cmp++;
        if (si !== 1'b1) begin
            n_bad++; $display("FAIL si_set_on_ack: got %b expected 1", si);
        end
        rd(A_MSIP, d);
        n_cmp++;
        if (d !== 32'h1) begin
            n_bad++; $display("FAIL msip_read: got %h expected 00000001", d);
        end
        wr(A_MSIP, 32'h0, 4'hF, ek, ti, si);
        n_cmp++;
        if (si !== 1'b0) begin
            n_bad++; $display("FAIL si_clr_on_ack: got %b expected 0", si);
        end
    endtask

    task automatic test_carry();
        int w1, ek; logic ti, si; logic [31:0] d;
        align(1);
        wr(A_MTL, 32'hFFFF_FFFE, 4'hF, w1, ti, si);
        wr(A_MTH, 32'h0, 4'hF, ek, ti, si);
        // Ticks at w1+3 and w1+7 give 0x1_0000_0000; read lo at w1+8.
        wait_cnt(w1 + 7);
        rd(A_MTL, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_bad++; $display("FAIL carry_lo: got %h expected 00000000", d);
        end
        rd(A_MTH, d);
        n_cmp++;
        if (d !== 32'h1) begin
            n_bad++; $display("FAIL carry_hi: got %h expected 00000001", d);
        end
    endtask

    task automatic test_wrap();
        int w1, ek; logic ti, si; logic [31:0] d;
        align(1);
        wr(A_MTL, 32'hFFFF_FFFF, 4'hF, w1, ti, si);
        wr(A_MTH, 32'hFFFF_FFFF, 4'hF, ek, ti, si);
        n_cmp++;
        if (ti !== 1'b1) begin
            n_bad++; $display("FAIL wrap_ti_before: got %b expected 1", ti);
        end
        // Edge w1+3 was a tick: mtime wrapped to 0.
        n_cmp++;
        if (timer_interrupt !== 1'b0) begin
            n_bad++; $display("FAIL wrap_ti_after: got %b expected 0", timer_interrupt);
        end
        rd(A_MTL, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_bad++; $display("FAIL wrap_lo: got %h expected 00000000", d);
        end
        rd(A_MTH, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_bad++; $display("FAIL wrap_hi: got %h expected 00000000", d);
        end
        align(0);
        wr(A_MTL, 32'h1234_5678, 4'hF, ek, ti, si);
        rd(A_MTL, d);
        n_cmp++;
        if (d !== 32'h1234_5678) begin
            n_bad++; $display("FAIL write_on_tick: got %h expected 12345678", d);
        end
    endtask

    task automatic test_shadow_bytes();
        int ek; logic ti, si; logic [31:0] d;
        rd(A_MTL, d);
        wr(A_MTH, 32'h55, 4'hF, ek, ti, si);
        rd(A_MTH, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_bad++; $display("FAIL shadow_stale: got %h expected 00000000", d);
        end
        rd(A_MTL, d);
        rd(A_MTH, d);
        n_cmp++;
        if (d !== 32'h55) begin
            n_bad++; $display("FAIL shadow_fresh: got %h expected 00000055", d);
        end
        wr(A_CMPL, 32'h0000_AB00, 4'b0010, ek, ti, si);
        rd(A_CMPL, d);
        n_cmp++;
        if (d !== 32'h0000_ABE8) begin
            n_bad++; $display("FAIL byte_write: got %h expected 0000abe8", d);
        end
        wr(A_UNMAP, 32'hDEAD_BEEF, 4'hF, ek, ti, si);
        rd(A_UNMAP, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_bad++; $display("FAIL unmapped_04: got %h expected 00000000", d);
        end
        rd(A_HOLE, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_bad++; $display("FAIL unmapped_1c: got %h expected 00000000", d);
        end
    endtask

    task automatic test_reset_mid_ack();
        logic [31:0] d;
        wb_adr_i = A_CMPL; wb_we_i = 1'b0; wb_sel_i = 4'h0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (wb_ack_o !== 1'b1) begin
            n_bad++; $display("FAIL pre_reset_ack: got %b expected 1", wb_ack_o);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin
            n_bad++; $display("FAIL async_reset_ack: got ack=%b dat=%h expected 0/00000000", wb_ack_o, wb_dat_o);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rd(A_MTL, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_bad++; $display("FAIL post_reset_mtime: got %h expected 00000000", d);
        end
        rd(A_CMPL, d);
        n_cmp++;
        if (d !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL post_reset_cmp: got %h expected ffffffff", d);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_timer_cmp();
        test_msip();
        test_carry();
        test_wrap();
        test_shadow_bytes();
        test_reset_mid_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
